// File: rtl/hpu_pkg.sv
// Shared HPU definitions: default bundling geometry, stream FSM state type and
// the saturating add used by every vote counter.
package hpu_pkg;

    localparam int DIM   = 1024;
    localparam int NCORE = 16;
    localparam int CW    = 26;
    localparam int SW    = 256;
    localparam int TIE   = 1;
    localparam int BEATS = DIM / SW;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // Adds delta to base and clamps to the range of a signed width-bit counter.
    function automatic longint sat_add(input longint base, input longint delta, input int width);
        longint sum;
        longint hi;
        longint lo;
        hi  = (longint'(1) <<< (width - 1)) - 1;
        lo  = -hi - 1;
        sum = base + delta;
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/bundle_counter.sv
// One dimension of the bundling accumulator: signed saturating vote counter over
// NCORE core bits, plus the majority sign with a configurable tie value.
module bundle_counter #(
    parameter int NCORE = 16,
    parameter int CW    = 26,
    parameter bit TIE   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCORE-1:0] res,
    input  logic [NCORE-1:0] store,
    input  logic             clr_eff,
    output logic             sign
);
    import hpu_pkg::sat_add;

    localparam int DW = $clog2(NCORE + 1) + 1;
    localparam logic signed [DW-1:0] ONE = DW'(1);

    logic signed [DW-1:0] delta;
    logic signed [CW-1:0] cnt;
    logic signed [CW-1:0] base;

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        delta = '0;
        for (int i = 0; i < NCORE; i++) begin
            if (store[i]) begin
                delta = res[i] ? (delta + ONE) : (delta - ONE);
            end
        end
    end

    // A clear restarts from zero but still counts this cycle's votes.
    assign base = clr_eff ? '0 : cnt;

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= CW'(sat_add(longint'(base), longint'(delta), CW));
        end
    end

    assign sign = cnt[CW-1] ? 1'b0 : ((cnt == '0) ? TIE : 1'b1);

endmodule

// File: rtl/bundle_stream_ctrl.sv
// Bundling accumulator with snapshot buffer and valid/ready stream-out of the
// majority hypervector in DIM/SW beats.
module bundle_stream_ctrl #(
    parameter int DIM   = hpu_pkg::DIM,
    parameter int NCORE = hpu_pkg::NCORE,
    parameter int CW    = hpu_pkg::CW,
    parameter int SW    = hpu_pkg::SW,
    parameter int TIE   = hpu_pkg::TIE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCORE*DIM-1:0] core_res,
    input  logic [NCORE-1:0]     store,
    input  logic                 clr,
    input  logic                 snap,
    input  logic                 snap_clr,
    output logic                 busy,
    output logic [DIM-1:0]       sign_bit,
    output logic [SW-1:0]        m_data,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready
);
    import hpu_pkg::state_t;
    import hpu_pkg::IDLE;
    import hpu_pkg::STREAM;

    localparam int BEATS = DIM / SW;
    localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);

    state_t         state;
    state_t         state_nxt;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  idx_nxt;
    logic [DIM-1:0] buffer;
    logic           snap_go;
    logic           clr_eff;
    logic           xfer;

    assign busy    = (state == STREAM);
    assign m_valid = busy;
    assign snap_go = snap && !busy;
    assign clr_eff = clr || (snap_go && snap_clr);
    assign xfer    = m_valid && m_ready;
    assign m_last  = m_valid && (idx == LAST_IDX);
    assign m_data  = m_valid ? buffer[SW*int'(idx) +: SW] : '0;

    for (genvar j = 0; j < DIM; j++) begin : g_dim
        logic [NCORE-1:0] res_bits;

        for (genvar i = 0; i < NCORE; i++) begin : g_core
            assign res_bits[i] = core_res[i*DIM + j];
        end

        bundle_counter #(
            .NCORE (NCORE),
            .CW    (CW),
            .TIE   (TIE != 0)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .res     (res_bits),
            .store   (store),
            .clr_eff (clr_eff),
            .sign    (sign_bit[j])
        );
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (snap) begin
                    state_nxt = STREAM;
                    idx_nxt   = '0;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // NOTE: the snapshot buffer is a plain register bank, not a RAM, so it is cleared on reset like any other state.
    // It captures the pre-edge sign vector, so same-cycle stores are excluded.
    always_ff @(posedge clk) begin
        if (rst) begin
            buffer <= '0;
        end else if (snap_go) begin
            buffer <= sign_bit;
        end
    end

endmodule

// File: tb/tb_bundle_stream_ctrl.sv
// Directed bench for bundle_stream_ctrl: a default-size instance for majority and
// streaming, plus a tiny CW=4 single-beat instance for saturation.
module tb_bundle_stream_ctrl;

    logic              clk;
    logic              rst;
    logic [16*1024-1:0] core_res;
    logic [15:0]       store;
    logic              clr;
    logic              snap;
    logic              snap_clr;
    logic              busy;
    logic [1023:0]     sign_bit;
    logic [255:0]      m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    logic [15:0]       s_core_res;
    logic [1:0]        s_store;
    logic              s_clr;
    logic              s_snap;
    logic              s_snap_clr;
    logic              s_busy;
    logic [7:0]        s_sign_bit;
    logic [7:0]        s_m_data;
    logic              s_m_valid;
    logic              s_m_last;
    logic              s_m_ready;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1023:0] pat;
    logic [1023:0] ones;

    bundle_stream_ctrl #(
        .DIM(1024), .NCORE(16), .CW(26), .SW(256), .TIE(1)
    ) dut (
        .clk(clk), .rst(rst), .core_res(core_res), .store(store), .clr(clr),
        .snap(snap), .snap_clr(snap_clr), .busy(busy), .sign_bit(sign_bit),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
    );

    bundle_stream_ctrl #(
        .DIM(8), .NCORE(2), .CW(4), .SW(8), .TIE(1)
    ) dut_small (
        .clk(clk), .rst(rst), .core_res(s_core_res), .store(s_store), .clr(s_clr),
        .snap(s_snap), .snap_clr(s_snap_clr), .busy(s_busy), .sign_bit(s_sign_bit),
        .m_data(s_m_data), .m_valid(s_m_valid), .m_last(s_m_last), .m_ready(s_m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_sign(input string tag, input logic [1023:0] exp);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s[%0d]", tag, k), sign_bit[k*256 +: 256], exp[k*256 +: 256]);
        end
    endtask

    task automatic set_core(input int core, input logic [1023:0] v);
        core_res[core*1024 +: 1024] = v;
    endtask

    // One-cycle clear while core 0 votes v: leaves every counter at +/-1, so sign_bit == v.
    task automatic load(input logic [1023:0] v);
        core_res = '0;
        set_core(0, v);
        store = 16'h0001;
        clr   = 1'b1;
        tick();
        clr   = 1'b0;
        store = '0;
        core_res = '0;
    endtask

    // Consumes a stream of 4 beats, checking each slice, m_last and stall stability.
    // A snap/snap_clr pulse is injected at cycle snap_at to show it is ignored while busy.
    task automatic drain(input logic [1023:0] exp, input bit toggle, input int snap_at, input string tag);
        int  beats;
        int  c;
        bit  xf;
        beats = 0;
        c     = 0;
        while (beats < 4 && c < 60) begin
            if (m_valid) begin
                check({tag, " data"}, m_data, exp[beats*256 +: 256]);
                check({tag, " last"}, m_last, beats == 3);
                check({tag, " busy"}, busy, 1'b1);
            end else begin
                check({tag, " valid"}, m_valid, 1'b1);
            end
            m_ready  = toggle ? (c % 3 == 0) : 1'b1;
            snap     = (c == snap_at);
            snap_clr = (c == snap_at);
            xf       = m_valid && m_ready;
            tick();
            if (xf) beats++;
            c++;
        end
        m_ready  = 1'b0;
        snap     = 1'b0;
        snap_clr = 1'b0;
        check({tag, " beats"}, beats, 4);
        check({tag, " valid_end"}, m_valid, 1'b0);
        check({tag, " busy_end"}, busy, 1'b0);
        check({tag, " last_end"}, m_last, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pat  = {{8{32'hdeadbeef}}, {8{32'h0f0ff0f0}}, {8{32'h9abcdef0}}, {8{32'h12345678}}};
        ones = '1;
        rst = 1'b1; core_res = '0; store = '0; clr = 0; snap = 0; snap_clr = 0; m_ready = 0;
        s_core_res = '0; s_store = '0; s_clr = 0; s_snap = 0; s_snap_clr = 0; s_m_ready = 0;

        // Reset
        repeat (3) tick();
        rst = 1'b0;
        check_sign("rst sign", ones);
        check("rst valid", m_valid, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst last", m_last, 1'b0);
        check("rst data", m_data, 256'h0);
        check("rst small sign", s_sign_bit, 8'hff);

        // Saturation on the CW=4 instance: +1 x10 clamps at 7
        s_store = 2'b01;
        s_core_res = 16'h00ff;
        repeat (10) tick();
        check("sat hi", s_sign_bit, 8'hff);
        s_core_res = 16'h0000;
        repeat (7) tick();
        check("sat 7 down to 0", s_sign_bit, 8'hff);
        tick();
        check("sat 8 down to -1", s_sign_bit, 8'h00);
        repeat (12) tick();
        check("sat lo", s_sign_bit, 8'h00);
        s_core_res = 16'h00ff;
        repeat (7) tick();
        check("sat -8 up to -1", s_sign_bit, 8'h00);
        tick();
        check("sat -8 up to 0", s_sign_bit, 8'hff);
        s_store = 2'b00;

        // Single-beat stream: first beat carries m_last
        s_core_res = 16'h00a5;
        s_store = 2'b01;
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        s_store = 2'b00;
        check("small load", s_sign_bit, 8'ha5);
        s_snap = 1'b1;
        tick();
        s_snap = 1'b0;
        check("small valid", s_m_valid, 1'b1);
        check("small last", s_m_last, 1'b1);
        check("small data", s_m_data, 8'ha5);
        s_m_ready = 1'b1;
        tick();
        s_m_ready = 1'b0;
        check("small valid end", s_m_valid, 1'b0);
        check("small busy end", s_busy, 1'b0);

        // Majority: 10 vs 6 on dim 5 -> +4; all other dims -16
        store = 16'hffff;
        for (int i = 0; i < 10; i++) core_res[i*1024 + 5] = 1'b1;
        tick();
        check("maj 10v6 lo", sign_bit[255:0], 256'h20);
        check("maj 10v6 hi", sign_bit[511:256], 256'h0);
        core_res = '0;
        for (int i = 0; i < 8; i++) core_res[i*1024 + 5] = 1'b1;
        tick();
        check("maj 8v8", sign_bit[255:0], 256'h20);
        core_res = '0;
        store = 16'h0001;
        repeat (3) tick();
        check("maj cnt 1", sign_bit[255:0], 256'h20);
        tick();
        check("maj cnt 0 tie", sign_bit[255:0], 256'h20);
        tick();
        check("maj cnt -1", sign_bit[255:0], 256'h0);
        store = '0;

        // Stream with backpressure, clr while busy, ignored snap_clr while busy
        load(pat);
        check_sign("load pat", pat);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        check("snap busy", busy, 1'b1);
        check("snap data0", m_data, pat[255:0]);
        set_core(0, ~pat);
        store = 16'h0001;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        store = '0;
        core_res = '0;
        check("clr busy sign", sign_bit[255:0], ~pat[255:0]);
        check("clr busy data", m_data, pat[255:0]);
        drain(pat, 1'b1, 4, "stream");
        check("snap_clr ignored", sign_bit[255:0], ~pat[255:0]);

        // snap_clr with same-cycle store on core 0
        set_core(0, ones);
        store = 16'h0001;
        snap = 1'b1;
        snap_clr = 1'b1;
        tick();
        snap = 1'b0;
        snap_clr = 1'b0;
        core_res = '0;
        check("snapclr sign lo", sign_bit[255:0], ones[255:0]);
        check("snapclr sign hi", sign_bit[1023:768], ones[1023:768]);
        check("snapclr data0", m_data, ~pat[255:0]);
        tick();
        check("snapclr cnt 0", sign_bit[255:0], ones[255:0]);
        tick();
        store = '0;
        check("snapclr cnt -1 lo", sign_bit[255:0], 256'h0);
        check("snapclr cnt -1 hi", sign_bit[1023:768], 256'h0);
        drain(~pat, 1'b0, -1, "snapclr");

        // Reset mid-stream at beat 2, then a fresh snapshot restarts at beat 0
        load(pat);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        m_ready = 1'b1;
        repeat (2) tick();
        m_ready = 1'b0;
        check("mid beat2 data", m_data, pat[767:512]);
        check("mid beat2 last", m_last, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst valid", m_valid, 1'b0);
        check("mid rst last", m_last, 1'b0);
        check("mid rst busy", busy, 1'b0);
        check("mid rst data", m_data, 256'h0);
        check("mid rst sign", sign_bit[255:0], ones[255:0]);
        load(pat);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        drain(pat, 1'b0, -1, "restart");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
